// File: rtl/tagger_input_deadtime.sv
// Per-line edge tagger: optional line inversion, first rising/falling edge search per
// oversampled word, and per-channel dead-time gating ahead of the timestamp stage.
module tagger_input_deadtime #(
  parameter int LINES   = 4,
  parameter int BITS    = 3,
  parameter int DT_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(2**BITS)*LINES-1:0]    samples_i,
  input  logic [LINES-1:0]              invert_i,
  input  logic [2*LINES-1:0]            enable_i,
  input  logic [DT_BITS-1:0]            deadtime_i,
  output logic [BITS*2*LINES-1:0]       subtimes_o,
  output logic [2*LINES-1:0]            edge_detected_o,
  output logic [2*LINES-1:0]            suppressed_o
);

  localparam int S  = 2**BITS;
  localparam int CH = 2*LINES;

  logic [S*LINES-1:0]    w_d, w_q;
  logic [LINES-1:0]      h_q;
  logic                  prime_q;
  logic                  detEn_q;
  logic [CH-1:0]         rawDet;
  logic [BITS*CH-1:0]    rawSub;
  logic [BITS*CH-1:0]    sub_q;
  logic [CH-1:0]         edge_q, supp_q;
  logic [DT_BITS-1:0]    cnt_q [CH];

  always_comb begin
    w_d = samples_i;
    for (int i = 0; i < LINES; i++) begin
      w_d[S*i +: S] = samples_i[S*i +: S] ^ {S{invert_i[i]}};
    end
  end

  // Stage 1: post-invert word plus the last sample of the previous word. detEn_q
  // lags prime_q by one so the very first word (with no real history) is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      h_q     <= '0;
      prime_q <= 1'b0;
      detEn_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      prime_q <= 1'b1;
      detEn_q <= prime_q;
      for (int i = 0; i < LINES; i++) begin
        h_q[i] <= w_q[S*i + S - 1];
      end
    end
  end

  // Scanning from the top down lets the lowest matching index overwrite earlier hits.
  always_comb begin : detect_b
    logic [S:0] seq;
    seq    = '0;
    rawDet = '0;
    rawSub = '0;
    for (int i = 0; i < LINES; i++) begin
      seq = {w_q[S*i +: S], h_q[i]};
      for (int k = S - 1; k >= 0; k--) begin
        if (seq[k+1] && !seq[k]) begin
          rawDet[i]                   = detEn_q;
          rawSub[BITS*i +: BITS]      = BITS'(k);
        end
        if (!seq[k+1] && seq[k]) begin
          rawDet[LINES+i]                 = detEn_q;
          rawSub[BITS*(LINES+i) +: BITS]  = BITS'(k);
        end
      end
    end
  end

  // Stage 2: dead-time gating. A suppressed hit still consumes one count, so an
  // accepted event at cycle T allows the next one at T+deadtime+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q  <= '0;
      edge_q <= '0;
      supp_q <= '0;
      for (int c = 0; c < CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        edge_q[c] <= 1'b0;
        supp_q[c] <= 1'b0;
        if (!enable_i[c]) begin
          cnt_q[c] <= '0;
        end else if (rawDet[c]) begin
          if (cnt_q[c] == '0) begin
            edge_q[c]              <= 1'b1;
            sub_q[BITS*c +: BITS]  <= rawSub[BITS*c +: BITS];
            cnt_q[c]               <= deadtime_i;
          end else begin
            supp_q[c] <= 1'b1;
            cnt_q[c]  <= cnt_q[c] - DT_BITS'(1);
          end
        end else if (cnt_q[c] != '0) begin
          cnt_q[c] <= cnt_q[c] - DT_BITS'(1);
        end
      end
    end
  end

  assign subtimes_o      = sub_q;
  assign edge_detected_o = edge_q;
  assign suppressed_o    = supp_q;

endmodule

// File: tb/tb_tagger_input_deadtime.sv
// Directed bench for tagger_input_deadtime: line 0 carries the stimulus, lines 1-3 idle low.
// Outputs seen at a given negedge reflect the word driven two negedges earlier.
module tb_tagger_input_deadtime;

  localparam int LINES   = 4;
  localparam int BITS    = 3;
  localparam int DT_BITS = 8;
  localparam int CH      = 2*LINES;

  logic                       clk;
  logic                       rst_n;
  logic [(2**BITS)*LINES-1:0] samples;
  logic [LINES-1:0]           invert;
  logic [CH-1:0]              enable;
  logic [DT_BITS-1:0]         deadtime;
  logic [BITS*CH-1:0]         subtimes;
  logic [CH-1:0]              edgeDetected;
  logic [CH-1:0]              suppressed;

  int nChecks;
  int nPass;

  tagger_input_deadtime #(
    .LINES  (LINES),
    .BITS   (BITS),
    .DT_BITS(DT_BITS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .samples_i      (samples),
    .invert_i       (invert),
    .enable_i       (enable),
    .deadtime_i     (deadtime),
    .subtimes_o     (subtimes),
    .edge_detected_o(edgeDetected),
    .suppressed_o   (suppressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a new line-0 word just after the falling edge.
  task automatic applyStimulus(input logic [7:0] w0);
    @(negedge clk);
    samples      = '0;
    samples[7:0] = w0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks  = 0;
    nPass    = 0;
    rst_n    = 1'b0;
    samples  = '0;
    invert   = '0;
    enable   = '1;
    deadtime = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_edge", 32'(edgeDetected), 32'h0);
    checkOutput("reset_supp", 32'(suppressed), 32'h0);
    checkOutput("reset_sub", 32'(subtimes), 32'h0);

    // Priming: first word 0xFF after release must not produce a rising edge
    applyStimulus(8'hFF); rst_n = 1'b1;                                   // s0
    applyStimulus(8'h00); checkOutput("prime_s1", 32'(edgeDetected), 32'h0);  // s1
    applyStimulus(8'h00); checkOutput("prime_blocked", 32'(edgeDetected), 32'h0); // s2
    applyStimulus(8'h00); checkOutput("prime_fall", 32'(edgeDetected), 32'h10);   // s3

    // Rising edge at subtime 3, falling channel silent
    applyStimulus(8'hF8); checkOutput("idle_s4", 32'(edgeDetected), 32'h0);  // s4
    applyStimulus(8'hFF); checkOutput("idle_s5", 32'(edgeDetected), 32'h0);  // s5
    applyStimulus(8'hFF);                                                    // s6
    checkOutput("rise3_edge", 32'(edgeDetected), 32'h01);
    checkOutput("rise3_sub", 32'(subtimes), 32'h000003);
    checkOutput("rise3_supp", 32'(suppressed), 32'h0);

    // Rising at 0 and falling at 2 of the same line in one cycle
    applyStimulus(8'h00); checkOutput("high_s7", 32'(edgeDetected), 32'h0);  // s7
    applyStimulus(8'h03); checkOutput("high_s8", 32'(edgeDetected), 32'h0);  // s8
    applyStimulus(8'h00); checkOutput("fall0_edge", 32'(edgeDetected), 32'h10); // s9
    applyStimulus(8'h00);                                                    // s10
    checkOutput("both_edge", 32'(edgeDetected), 32'h11);
    checkOutput("both_sub", 32'(subtimes), 32'h002000);

    // Dead time 4 with an edge on both channels every cycle
    deadtime = 8'd4;
    applyStimulus(8'h0F);                                                    // s11
    applyStimulus(8'h0F);                                                    // s12
    for (int i = 0; i <= 10; i++) begin                                      // s13..s23
      applyStimulus(8'h0F);
      checkOutput($sformatf("dt_edge_%0d", i), 32'(edgeDetected),
                  (i % 5 == 0) ? 32'h11 : 32'h00);
      checkOutput($sformatf("dt_supp_%0d", i), 32'(suppressed),
                  (i % 5 == 0) ? 32'h00 : 32'h11);
      if (i == 0) checkOutput("dt_sub", 32'(subtimes), 32'h004000);
    end

    // Inverted line: raw 0xFF idle then raw 0x07 reads as rising at subtime 3
    deadtime = 8'd0;
    invert   = 4'b0001;
    applyStimulus(8'hFF);                                                    // s24
    applyStimulus(8'hFF);                                                    // s25
    applyStimulus(8'hFF);                                                    // s26
    applyStimulus(8'hFF);                                                    // s27
    applyStimulus(8'h07);                                                    // s28
    applyStimulus(8'hFF);                                                    // s29
    applyStimulus(8'hFF);                                                    // s30
    checkOutput("inv_edge", 32'(edgeDetected), 32'h01);
    checkOutput("inv_sub", 32'(subtimes), 32'h004003);

    // Enable gating clears the dead-time counter
    applyStimulus(8'hFF);                                                    // s31
    deadtime = 8'd10;
    applyStimulus(8'hF0);                                                    // s32
    applyStimulus(8'hF0);                                                    // s33
    applyStimulus(8'hF0);                                                    // s34
    checkOutput("en_accept", 32'(edgeDetected), 32'h11);
    applyStimulus(8'hF0); enable[0] = 1'b0;                                  // s35
    checkOutput("en_supp_both", 32'(suppressed), 32'h11);
    applyStimulus(8'hF0);                                                    // s36
    checkOutput("dis_edge", 32'(edgeDetected), 32'h00);
    checkOutput("dis_supp", 32'(suppressed), 32'h10);
    applyStimulus(8'hF0); enable[0] = 1'b1;                                  // s37
    checkOutput("dis2_supp", 32'(suppressed), 32'h10);
    applyStimulus(8'hF0);                                                    // s38
    checkOutput("reen_edge", 32'(edgeDetected), 32'h01);
    checkOutput("reen_supp", 32'(suppressed), 32'h10);
    applyStimulus(8'hF0);                                                    // s39
    checkOutput("pre_rst_supp", 32'(suppressed), 32'h11);

    // Asynchronous reset away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_edge", 32'(edgeDetected), 32'h0);
    checkOutput("async_supp", 32'(suppressed), 32'h0);
    checkOutput("async_sub", 32'(subtimes), 32'h0);

    // Priming repeats after release; counters start cleared
    applyStimulus(8'hF0); rst_n = 1'b1;                                      // r0
    applyStimulus(8'hF0); checkOutput("reprime_r1", 32'(edgeDetected), 32'h0);
    applyStimulus(8'hF0); checkOutput("reprime_r2", 32'(edgeDetected), 32'h0);
    applyStimulus(8'hF0); checkOutput("reprime_r3", 32'(edgeDetected), 32'h11);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
